i2d_imem: RTL and testbench
===========================

Name: i2d_imem

Overview:
Wishbone classic slave: the instruction/boot memory that answers the i2d instruction-fetch master's bus cycles. Decodes the fetch address, inserts a configurable number of wait states, and terminates each cycle with exactly one of ack_o, rty_o or err_o. Also accepts word writes on the same bus so a loader or debug master can fill program memory before the core is released.

Parameters:
AW, 10, word-address bits; memory depth is 2**AW 32-bit words.
BASE, 32'h0000_0000, byte base address of the memory window; must be aligned to 4*2**AW.
WAIT_STATES, 1, idle cycles between accepting a request and its termination; range 0..15.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
adr_i  in  32  byte address from the bus master.
dat_i  in  32  write data.
dat_o  out  32  read data; valid in the ack_o cycle of a read.
we_i  in  1  1 = write, 0 = read.
cyc_i  in  1  bus cycle valid.
stb_i  in  1  strobe; request = cyc_i & stb_i.
ack_o  out  1  normal termination, 1-cycle pulse.
rty_o  out  1  retry termination, 1-cycle pulse.
err_o  out  1  error termination, 1-cycle pulse.
hold_i  in  1  memory unavailable; requests get retried while high.

Behaviour:
- Reset (rst=1 at a clock edge): state becomes IDLE, wait counter becomes 0, and dat_o, ack_o, rty_o, err_o become 0. Memory contents are not cleared. A reset during WAIT or RESP abandons the cycle with no termination, and a pending write is not performed.
- States: IDLE, WAIT, RESP.
- IDLE: on cyc_i & stb_i, latch adr_i, we_i, dat_i and classify the request.
  - ERR class: adr_i[1:0] != 0, or adr_i is outside [BASE, BASE + 4*2**AW).
  - RTY class: not ERR and hold_i=1.
  - OK class: everything else.
  - Priority is ERR > RTY > OK.
  - ERR and RTY go to RESP next cycle and pulse err_o or rty_o in that cycle. Latency is 1 cycle, independent of WAIT_STATES.
  - OK with WAIT_STATES=0 goes to RESP. OK with WAIT_STATES>0 loads the counter and goes to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1. If cyc_i drops, go to IDLE with no termination and no write (abort). hold_i is ignored once a request is in WAIT.
- RESP (one cycle): assert exactly one of ack_o, rty_o or err_o.
  - OK read: dat_o = mem[(adr - BASE) >> 2] in the same cycle as ack_o.
  - OK write: mem is written at the clock edge ending RESP; dat_o is unchanged.
  - Next state is always IDLE. A master that keeps stb_i high after a termination starts a new request, evaluated in IDLE on the following cycle. The minimum spacing between terminations is therefore 2 + WAIT_STATES cycles for OK requests and 2 cycles for ERR/RTY.
- OK latency: from the request-sample edge in IDLE to the ack_o cycle is 1 + WAIT_STATES cycles.
- dat_o holds its last read value between acks, and holds 0 after reset.
- Outputs are registered. The termination signals are mutually exclusive and never high for two consecutive cycles.
- Address index arithmetic: word index = (adr_i - BASE)[AW+1:2]. The top word (index 2**AW-1) is valid; BASE + 4*2**AW gives err_o.

Test Plan:
- Reset mid-WAIT with WAIT_STATES=3: assert rst 2 cycles after a read request. Required: no ack_o, all outputs 0, next request behaves normally.
- Write/read back, BASE=0, WAIT_STATES=1: write 32'hDEAD_BEEF to adr 0x10, then read adr 0x10. Required: each ack_o arrives 2 cycles after the request edge; the read returns dat_o=32'hDEAD_BEEF.
- Misaligned and out-of-range, AW=10: read adr 0x2 and adr 0x1000. Required: err_o pulses 1 cycle after each request, no ack_o. A read of adr 0xFFC acks normally.
- Retry: hold_i=1 while reading adr 0x0. Required: rty_o pulses 1 cycle later. With stb_i held, the next cycle retries again while hold_i=1; after hold_i drops, ack_o follows with correct data.
- Abort: a write request with WAIT_STATES=3, then cyc_i drops after 1 cycle. Required: no termination pulse and the memory word is unchanged on read-back.
- Back-to-back fetch stream, WAIT_STATES=0: stb_i held high, address incrementing by 4 after each ack. Required: ack_o every 2nd cycle with sequential preloaded words, and rty_o/err_o stay 0.

Source files
------------

// File: rtl/i2d_imem.sv
// i2d_imem -- instruction/boot memory, Wishbone classic slave.
//
// This module answers instruction fetches from the i2d core and word writes
// from a loader or debug master. Each accepted request ends with exactly one
// single-cycle termination: ack_o, rty_o or err_o.
// - A misaligned or out-of-window address ends with err_o after 1 cycle.
// - A request made while hold_i is high ends with rty_o after 1 cycle.
// - A normal request ends with ack_o after 1 + WAIT_STATES cycles.
// If the master drops cyc_i during the wait states, the cycle is abandoned
// quietly: there is no termination and no write.
//
// Parameters
//   AW          word-address bits; the memory holds 2**AW 32-bit words
//   BASE        byte base address of the window, aligned to 4*2**AW
//   WAIT_STATES cycles inserted before ack_o on normal requests (0..15)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   adr_i   byte address          dat_i   write data
//   dat_o   read data, valid with ack_o, held between reads
//   we_i    1 = write, 0 = read
//   cyc_i   bus cycle valid       stb_i   strobe
//   ack_o   normal termination    rty_o   retry termination
//   err_o   error termination
//   hold_i  memory unavailable; new requests are retried while high
module i2d_imem #(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        rty_o,
  output logic        err_o,
  input  logic        hold_i
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_ack;
  logic          r_rty;
  logic          r_err;
  logic [31:0]   r_dat_o;
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [31:0]   r_wdat;
  logic [31:0]   r_mem [2**AW];

  state_t        w_state_n;
  logic [3:0]    w_cnt_n;
  logic          w_ack_n;
  logic          w_rty_n;
  logic          w_err_n;
  logic          w_latch;
  logic          w_rd_n;
  logic [AW-1:0] w_rd_idx;
  logic          w_req;
  logic [31:0]   w_off;
  logic          w_in_range;
  logic          w_is_err;
  logic          w_is_rty;

  // Address decode. Offsets below BASE wrap to large unsigned values, so a
  // single "no bits above the window" test covers both ends of the range.
  assign w_req      = cyc_i & stb_i;
  assign w_off      = adr_i - BASE;
  assign w_in_range = (w_off >> (AW + 2)) == 32'd0;
  assign w_is_err   = (adr_i[1:0] != 2'b00) | ~w_in_range;
  assign w_is_rty   = ~w_is_err & hold_i;

  // A zero-wait read indexes straight from the bus address, because the
  // request has not been latched yet. A read from WAIT uses the latched index.
  assign w_rd_idx = (r_state == IDLE) ? w_off[AW+1:2] : r_idx;

  // NOTE: every signal gets a default before the case statement. This way no
  // path leaves a value unassigned, and so no latch is inferred.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ack_n   = 1'b0;
    w_rty_n   = 1'b0;
    w_err_n   = 1'b0;
    w_latch   = 1'b0;
    w_rd_n    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (w_is_err) begin
            w_err_n   = 1'b1;
            w_state_n = RESP;
          end else if (w_is_rty) begin
            w_rty_n   = 1'b1;
            w_state_n = RESP;
          end else if (WAIT_STATES == 0) begin
            w_ack_n   = 1'b1;
            w_rd_n    = ~we_i;
            w_state_n = RESP;
          end else begin
            w_cnt_n   = WS;
            w_state_n = WAIT;
          end
        end
      end
      WAIT: begin
        // A dropped cyc_i takes priority over the counter: the cycle is
        // abandoned with no termination.
        if (!cyc_i) begin
          w_state_n = IDLE;
        end else if (r_cnt == 4'd1) begin
          w_ack_n   = 1'b1;
          w_rd_n    = ~r_we;
          w_state_n = RESP;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_rty   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= 32'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ack   <= w_ack_n;
      r_rty   <= w_rty_n;
      r_err   <= w_err_n;
      if (w_rd_n) r_dat_o <= r_mem[w_rd_idx];
    end
  end

  // NOTE: the memory array and the request latches have no reset. Program
  // contents must survive a core reset, and the latches are only read after
  // a request has loaded them.
  // The write commits at the edge that ends RESP. It is skipped if reset
  // lands on that edge.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_idx  <= w_off[AW+1:2];
      r_we   <= we_i;
      r_wdat <= dat_i;
    end
    if (!rst && r_state == RESP && r_ack && r_we) r_mem[r_idx] <= r_wdat;
  end

  assign dat_o = r_dat_o;
  assign ack_o = r_ack;
  assign rty_o = r_rty;
  assign err_o = r_err;

endmodule

// File: tb/tb_i2d_imem.sv
// Directed testbench for i2d_imem. It uses three instances, with WAIT_STATES
// set to 1, 3 and 0. They share the bus inputs. Only the instance picked by
// 'sel' sees cyc_i, and its outputs are the ones observed.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_i2d_imem;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        hold;
  int          sel;

  logic        cyc1, cyc3, cyc0;
  logic [31:0] dat1, dat3, dat0;
  logic        ack1, rty1, err1;
  logic        ack3, rty3, err3;
  logic        ack0, rty0, err0;

  logic [31:0] obs_dat;
  logic [2:0]  obs_term;  // {err, rty, ack}

  int n_vec;
  int n_mis;

  assign cyc1 = cyc && (sel == 1);
  assign cyc3 = cyc && (sel == 3);
  assign cyc0 = cyc && (sel == 0);

  i2d_imem #(.AW(10), .BASE(32'h0), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat1),
    .we_i(we), .cyc_i(cyc1), .stb_i(stb), .ack_o(ack1), .rty_o(rty1),
    .err_o(err1), .hold_i(hold)
  );

  i2d_imem #(.AW(10), .BASE(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat3),
    .we_i(we), .cyc_i(cyc3), .stb_i(stb), .ack_o(ack3), .rty_o(rty3),
    .err_o(err3), .hold_i(hold)
  );

  i2d_imem #(.AW(10), .BASE(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat0),
    .we_i(we), .cyc_i(cyc0), .stb_i(stb), .ack_o(ack0), .rty_o(rty0),
    .err_o(err0), .hold_i(hold)
  );

  always_comb begin
    obs_dat  = dat1;
    obs_term = {err1, rty1, ack1};
    if (sel == 3) begin
      obs_dat  = dat3;
      obs_term = {err3, rty3, ack3};
    end else if (sel == 0) begin
      obs_dat  = dat0;
      obs_term = {err0, rty0, ack0};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request. Count cycles from the sampling edge up to the first
  // termination (within a bound), then release the bus. Then check that the
  // termination is a one-cycle pulse.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat,
                      input logic [2:0] exp_term, input logic [31:0] exp_dat);
    int         lat;
    logic [2:0] term;
    @(negedge clk);
    adr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
    lat  = 0;
    term = 3'b000;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (obs_term != 3'b000) begin
        lat  = k;
        term = obs_term;
      end
    end
    check({tag, " dat"}, obs_dat, exp_dat);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, " term"}, {29'd0, term}, {29'd0, exp_term});
    check({tag, " lat"}, lat, exp_lat);
    @(negedge clk);
    check({tag, " pulse"}, {29'd0, obs_term}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1; adr = 32'd0; wdat = 32'd0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; hold = 1'b0; sel = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        sel = k;
        #1;
        check("reset term", {29'd0, obs_term}, 32'd0);
        check("reset dat", obs_dat, 32'd0);
      end
    end
    rst = 1'b0;

    // ---- WAIT_STATES = 1: write/read back, error classes, top word ----
    sel = 1;
    xfer("ws1 wr 0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 3'b001, 32'h0);
    xfer("ws1 rd 0x10", 1'b0, 32'h10, 32'h0, 2, 3'b001, 32'hDEAD_BEEF);
    xfer("ws1 misalign 0x2", 1'b0, 32'h2, 32'h0, 1, 3'b100, 32'hDEAD_BEEF);
    xfer("ws1 oor 0x1000", 1'b0, 32'h1000, 32'h0, 1, 3'b100, 32'hDEAD_BEEF);
    xfer("ws1 wr 0xFFC", 1'b1, 32'hFFC, 32'h1234_5678, 2, 3'b001, 32'hDEAD_BEEF);
    xfer("ws1 rd 0xFFC", 1'b0, 32'hFFC, 32'h0, 2, 3'b001, 32'h1234_5678);
    xfer("ws1 wr 0x0", 1'b1, 32'h0, 32'hA5A5_0001, 2, 3'b001, 32'h1234_5678);

    // ---- Retry: stb held while hold_i is high, then released ----
    @(negedge clk);
    adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1; hold = 1'b1;
    @(negedge clk);
    check("rty first", {29'd0, obs_term}, 32'd2);
    @(negedge clk);
    check("rty gap1", {29'd0, obs_term}, 32'd0);
    @(negedge clk);
    check("rty second", {29'd0, obs_term}, 32'd2);
    hold = 1'b0;
    @(negedge clk);
    check("rty gap2", {29'd0, obs_term}, 32'd0);
    @(negedge clk);
    check("rty wait", {29'd0, obs_term}, 32'd0);
    @(negedge clk);
    check("rty ack", {29'd0, obs_term}, 32'd1);
    check("rty ack dat", obs_dat, 32'hA5A5_0001);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rty ack pulse", {29'd0, obs_term}, 32'd0);

    // ---- WAIT_STATES = 3: reset mid-WAIT, then abort ----
    sel = 3;
    xfer("ws3 wr 0x20", 1'b1, 32'h20, 32'h0BAD_F00D, 4, 3'b001, 32'h0);
    xfer("ws3 rd 0x20", 1'b0, 32'h20, 32'h0, 4, 3'b001, 32'h0BAD_F00D);
    @(negedge clk);
    adr = 32'h20; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("rstwait pre", {29'd0, obs_term}, 32'd0);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rstwait term", {29'd0, obs_term}, 32'd0);
    check("rstwait dat", obs_dat, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rstwait quiet", {29'd0, obs_term}, 32'd0);
    end
    xfer("ws3 rd after rst", 1'b0, 32'h20, 32'h0, 4, 3'b001, 32'h0BAD_F00D);

    @(negedge clk);
    adr = 32'h20; wdat = 32'hFFFF_FFFF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort quiet", {29'd0, obs_term}, 32'd0);
    end
    xfer("ws3 rd after abort", 1'b0, 32'h20, 32'h0, 4, 3'b001, 32'h0BAD_F00D);

    // ---- WAIT_STATES = 0: preload, then back-to-back fetch stream ----
    sel = 0;
    for (int i = 0; i < 4; i++)
      xfer("ws0 preload", 1'b1, 32'h40 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1, 3'b001, 32'h0);
    @(negedge clk);
    adr = 32'h40; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream ack", {29'd0, obs_term}, 32'd1);
      check("stream dat", obs_dat, 32'hC0DE_0000 + 32'(i));
      adr = adr + 32'd4;
      @(negedge clk);
      check("stream gap", {29'd0, obs_term}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("stream end", {29'd0, obs_term}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
